// File: rtl/result_write_arbiter_pkg.sv
// Shared widths and helpers for the result-RAM write arbiter.
// Lane count, result width and row-id width defaults live here so every file agrees.
package result_write_arbiter_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int MULT_BITS   = 32;
    localparam int ROW_ID_BITS = 16;
    localparam int CNT_W_DEF   = 32;

    // Lane-index width; kept at least 1 so a degenerate lane count still elaborates.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_write_arbiter_if.sv
// Lane-side and RAM-side signals of the result write arbiter.
// slave is the arbiter's view; master is the surrounding logic's view.
interface result_write_arbiter_if #(
    parameter int NUM_CH = result_write_arbiter_pkg::NUM_CH_DEF,
    parameter int DATA_W = result_write_arbiter_pkg::MULT_BITS,
    parameter int ADDR_W = result_write_arbiter_pkg::ROW_ID_BITS,
    parameter int CNT_W  = result_write_arbiter_pkg::CNT_W_DEF
);
    import result_write_arbiter_pkg::*;

    localparam int IDX_W = idx_w(NUM_CH);

    logic [NUM_CH-1:0]        ch_wr_en;
    logic [NUM_CH*ADDR_W-1:0] ch_wr_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wr_data;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH-1:0]        ch_full;
    logic [NUM_CH-1:0]        ch_err;
    logic                     mem_ready;
    logic                     mem_wr_en;
    logic [ADDR_W-1:0]        mem_wr_addr;
    logic [DATA_W-1:0]        mem_wr_data;
    logic [IDX_W-1:0]         mem_wr_ch;
    logic [CNT_W-1:0]         wr_count;
    logic                     all_done;

    modport slave (
        input  ch_wr_en, ch_wr_addr, ch_wr_data, ch_done, mem_ready,
        output ch_full, ch_err, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_ch,
               wr_count, all_done
    );

    modport master (
        output ch_wr_en, ch_wr_addr, ch_wr_data, ch_done, mem_ready,
        input  ch_full, ch_err, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_ch,
               wr_count, all_done
    );

endinterface

// File: rtl/result_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
// Produces a one-hot grant plus the granted index.
module result_write_arbiter_rr_arbiter
    import result_write_arbiter_pkg::*;
#(
    parameter int N = NUM_CH_DEF
) (
    input  logic [N-1:0]          req_i,
    input  logic [idx_w(N)-1:0]   ptr_i,
    output logic [N-1:0]          gnt_o,
    output logic [idx_w(N)-1:0]   gnt_idx_o,
    output logic                  gnt_valid_o
);
    localparam int IDX_W = idx_w(N);

    int j;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!gnt_valid_o && req_i[j[IDX_W-1:0]]) begin
                gnt_valid_o           = 1'b1;
                gnt_o[j[IDX_W-1:0]]   = 1'b1;
                gnt_idx_o             = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Shares one result-RAM write port among NUM_CH lanes, each with a 1-entry slot,
// through a round-robin grant into a registered output stage.
module result_write_arbiter
    import result_write_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = MULT_BITS,
    parameter int ADDR_W = ROW_ID_BITS,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    result_write_arbiter_if.slave  wr_if
);
    localparam int IDX_W = idx_w(NUM_CH);

    logic [NUM_CH-1:0] slot_valid_q, slot_valid_d;
    logic [ADDR_W-1:0] slot_addr_q [NUM_CH];
    logic [DATA_W-1:0] slot_data_q [NUM_CH];
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [IDX_W-1:0]  mem_wr_ch_q, mem_wr_ch_d;
    logic [NUM_CH-1:0] ch_err_q, ch_err_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              all_done_q, all_done_d;

    logic              out_load;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] capture;

    // The output register may take a new write when empty or when the RAM drains it now.
    assign out_load = ~mem_wr_en_q | wr_if.mem_ready;
    assign req      = slot_valid_q & {NUM_CH{out_load}};

    result_write_arbiter_rr_arbiter #(.N(NUM_CH)) u_rr (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // A slot leaving this cycle is reported free so its lane can refill it immediately.
    assign ch_full = slot_valid_q & ~gnt;
    assign capture = wr_if.ch_wr_en & ~ch_full;

    always_comb begin
        slot_valid_d  = (slot_valid_q & ~gnt) | capture;
        ch_err_d      = ch_err_q | (wr_if.ch_wr_en & ch_full);
        ptr_d         = ptr_q;
        mem_wr_en_d   = mem_wr_en_q;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_ch_d   = mem_wr_ch_q;
        if (gnt_valid) begin
            mem_wr_en_d   = 1'b1;
            mem_wr_addr_d = slot_addr_q[gnt_idx];
            mem_wr_data_d = slot_data_q[gnt_idx];
            mem_wr_ch_d   = gnt_idx;
            ptr_d         = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (wr_if.mem_ready) begin
            mem_wr_en_d   = 1'b0;
        end
        wr_count_d = wr_count_q;
        if (mem_wr_en_q && wr_if.mem_ready) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
        all_done_d = (&wr_if.ch_done) & ~(|slot_valid_q) & ~mem_wr_en_q & ~(|wr_if.ch_wr_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid_q  <= '0;
            ptr_q         <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            mem_wr_ch_q   <= '0;
            ch_err_q      <= '0;
            wr_count_q    <= '0;
            all_done_q    <= 1'b0;
        end else begin
            slot_valid_q  <= slot_valid_d;
            ptr_q         <= ptr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_ch_q   <= mem_wr_ch_d;
            ch_err_q      <= ch_err_d;
            wr_count_q    <= wr_count_d;
            all_done_q    <= all_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture[i]) begin
                    slot_addr_q[i] <= wr_if.ch_wr_addr[i*ADDR_W +: ADDR_W];
                    slot_data_q[i] <= wr_if.ch_wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign wr_if.ch_full     = ch_full;
    assign wr_if.ch_err      = ch_err_q;
    assign wr_if.mem_wr_en   = mem_wr_en_q;
    assign wr_if.mem_wr_addr = mem_wr_addr_q;
    assign wr_if.mem_wr_data = mem_wr_data_q;
    assign wr_if.mem_wr_ch   = mem_wr_ch_q;
    assign wr_if.wr_count    = wr_count_q;
    assign wr_if.all_done    = all_done_q;

endmodule
